// File: rtl/preg_free_list.sv
// Physical register free list for rename: LSB-first allocation,
// commit-side frees, and a single branch checkpoint for rollback.
module preg_free_list #(
    parameter int NUM_PREGS    = 64,
    parameter int RESET_MAPPED = 32,
    localparam int IW          = $clog2(NUM_PREGS),
    localparam int CW          = $clog2(NUM_PREGS) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc_req,
    output logic          alloc_gnt,
    output logic [IW-1:0] alloc_preg,
    input  logic          free_valid,
    input  logic [IW-1:0] free_preg,
    input  logic          ckpt_save,
    input  logic          ckpt_restore,
    output logic [CW-1:0] free_cnt,
    output logic          empty,
    output logic          double_free_err
);

    localparam logic [CW-1:0] RST_CNT = CW'(NUM_PREGS - RESET_MAPPED);
    localparam logic [CW-1:0] MAX_CNT = CW'(NUM_PREGS);

    logic [NUM_PREGS-1:0] r_free_vec;
    logic [NUM_PREGS-1:0] r_ckpt_vec;
    logic [CW-1:0]        r_free_cnt;
    logic [CW-1:0]        r_ckpt_cnt;
    logic                 r_empty;
    logic                 r_dfe;

    logic [NUM_PREGS-1:0] w_rst_vec;
    logic [IW-1:0]        w_sel;
    logic                 w_gnt;
    logic                 w_free_ok;
    logic                 w_free_dup;
    logic                 w_ck_inc;
    logic [NUM_PREGS-1:0] w_nxt_vec;
    logic [CW-1:0]        w_nxt_cnt;
    logic [NUM_PREGS-1:0] w_ck_vec;
    logic [CW-1:0]        w_ck_cnt;

    always_comb begin
        w_rst_vec = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            w_rst_vec[i] = (i >= RESET_MAPPED);
        end
    end

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_PREGS - 1; i >= 0; i--) begin
            if (r_free_vec[i]) begin
                w_sel = IW'(i);
            end
        end
    end

    assign w_gnt      = rst_n && alloc_req && !r_empty && !ckpt_restore;
    assign w_free_ok  = free_valid && (free_preg != '0)
                        && !r_free_vec[free_preg];
    assign w_free_dup = free_valid && (free_preg != '0)
                        && r_free_vec[free_preg];

    always_comb begin
        w_nxt_vec = r_free_vec;
        if (w_gnt) begin
            w_nxt_vec[w_sel] = 1'b0;
        end
        if (w_free_ok) begin
            w_nxt_vec[free_preg] = 1'b1;
        end
        w_nxt_cnt = r_free_cnt - CW'(w_gnt) + CW'(w_free_ok);
    end

    // Committed frees also land in the snapshot so they survive a rollback.
    always_comb begin
        w_ck_vec = r_ckpt_vec;
        w_ck_inc = w_free_ok && !r_ckpt_vec[free_preg];
        if (w_free_ok) begin
            w_ck_vec[free_preg] = 1'b1;
        end
        if (r_ckpt_cnt == MAX_CNT) begin
            w_ck_cnt = r_ckpt_cnt;
        end else begin
            w_ck_cnt = r_ckpt_cnt + CW'(w_ck_inc);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_free_vec <= w_rst_vec;
            r_ckpt_vec <= w_rst_vec;
            r_free_cnt <= RST_CNT;
            r_ckpt_cnt <= RST_CNT;
            r_empty    <= 1'b0;
            r_dfe      <= 1'b0;
        end else begin
            if (w_free_dup) begin
                r_dfe <= 1'b1;
            end
            if (ckpt_restore) begin
                r_free_vec <= w_ck_vec;
                r_free_cnt <= w_ck_cnt;
                r_empty    <= (w_ck_cnt == '0);
                r_ckpt_vec <= w_ck_vec;
                r_ckpt_cnt <= w_ck_cnt;
            end else begin
                r_free_vec <= w_nxt_vec;
                r_free_cnt <= w_nxt_cnt;
                r_empty    <= (w_nxt_cnt == '0);
                if (ckpt_save) begin
                    r_ckpt_vec <= w_nxt_vec;
                    r_ckpt_cnt <= w_nxt_cnt;
                end else begin
                    r_ckpt_vec <= w_ck_vec;
                    r_ckpt_cnt <= w_ck_cnt;
                end
            end
        end
    end

    assign alloc_gnt       = w_gnt;
    assign alloc_preg      = w_sel;
    assign free_cnt        = r_free_cnt;
    assign empty           = r_empty;
    assign double_free_err = r_dfe;

endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 Parameter: NUM_PREGS, default 64, number of physical registers; power of two, >= 8.
REQ-002 Parameter: RESET_MAPPED, default 32, pregs 0..RESET_MAPPED-1 are architecturally mapped at reset; range 1..NUM_PREGS-1.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: alloc_req  input  1  rename stage requests one free preg this cycle.
REQ-006 Port: alloc_gnt  output  1  request granted this cycle; combinational.
REQ-007 Port: alloc_preg  output  $clog2(NUM_PREGS)  granted preg index; combinational; valid only when alloc_gnt=1.
REQ-008 Port: free_valid  input  1  commit stage returns a preg.
REQ-009 Port: free_preg  input  $clog2(NUM_PREGS)  preg being returned.
REQ-010 Port: ckpt_save  input  1  snapshot allocation state, e.g. at branch rename.
REQ-011 Port: ckpt_restore  input  1  roll back to snapshot on mispredict.
REQ-012 Port: free_cnt  output  $clog2(NUM_PREGS)+1  registered count of free pregs.
REQ-013 Port: empty  output  1  registered; 1 when free_cnt==0.
REQ-014 Port: double_free_err  output  1  sticky error flag; registered.

Function
REQ-015 State: free_vec[NUM_PREGS] (1=free), ckpt_vec[NUM_PREGS], free_cnt, ckpt_cnt, double_free_err.
REQ-016 Selection: alloc_preg is the lowest-index set bit of free_vec (LSB-first priority encode; may instantiate priority_encoder, WIDTH=NUM_PREGS).
REQ-017 alloc_gnt = alloc_req && !empty && !ckpt_restore; zero-latency grant, one preg per cycle max.
REQ-018 On grant, bit alloc_preg of free_vec clears at the next edge; free_cnt decrements.
REQ-019 Free accepted when free_valid && free_preg!=0 && free_vec[free_preg]==0; it sets free_vec[free_preg] and ckpt_vec[free_preg] at the next edge; free_cnt increments.
REQ-020 A free is visible to selection only from the next cycle; a same-cycle free never satisfies a same-cycle request, even when empty.
REQ-021 Grant and accepted free in the same cycle: free_cnt unchanged, both bit updates applied.
REQ-022 free_preg==0 is silently ignored; preg 0 is never free and never granted.
REQ-023 free_valid to an already-free preg (nonzero): ignored; double_free_err sets to 1 and holds until reset.
REQ-024 ckpt_save (no restore): ckpt_vec <= next free_vec and ckpt_cnt <= next free_cnt, i.e. including this cycle's grant and free.
REQ-025 ckpt_restore: free_vec <= ckpt_vec with any accepted same-cycle free bit also set; free_cnt <= ckpt_cnt + that free; grant suppressed.
REQ-026 ckpt_save and ckpt_restore together: restore wins; snapshot then equals restored state.
REQ-027 Accepted frees between save and restore update ckpt_vec/ckpt_cnt so committed frees survive rollback; ckpt_cnt saturates at NUM_PREGS.
REQ-028 Invariant: free_cnt always equals popcount(free_vec); empty == (free_cnt==0).

Reset
REQ-029 On clk edge with rst_n=0: free_vec bits RESET_MAPPED..NUM_PREGS-1 =1, others 0; ckpt_vec = same; free_cnt = ckpt_cnt = NUM_PREGS-RESET_MAPPED; empty=0; double_free_err=0.
REQ-030 Reset overrides all inputs in that cycle, including mid-restore or mid-grant; alloc_gnt is 0 while rst_n=0.

Verification
REQ-031 After reset, alloc_req held high 32 cycles -> grants p32..p63 in order, free_cnt 32->0, empty=1, cycle 33 alloc_gnt=0.
REQ-032 Empty, same cycle alloc_req=1 and free p40 -> alloc_gnt=0; next cycle alloc_gnt=1, alloc_preg=40, free_cnt returns to 0.
REQ-033 Grant p32 and free p5 same cycle -> free_cnt stays 32; next selection p5.
REQ-034 Free p0 -> no change; free p50 while free -> double_free_err=1, free_cnt unchanged, flag persists.
REQ-035 ckpt_save, grant p32..p35, free p3, ckpt_restore -> free_vec = reset vector plus p3, free_cnt=33, next grant p3.
REQ-036 rst_n=0 during ckpt_restore with alloc_req=1 -> reset state of REQ-029, alloc_gnt=0.
